mem_ctrl_icache: RTL
====================

Name: mem_ctrl_icache

Overview:
Memory controller between the CPU core and the byte-serial main memory, successor to the fixed 4-byte fetch/access unit. It adds byte, half and word access sizes with sign/zero extension, and a parametrised direct-mapped instruction cache. Data accesses take priority over instruction fetches, and reset is synchronous. It sits between the IF/MEM stages and the 1-byte-wide RAM port.

Parameters:
ADDR_WIDTH, 17, byte address width; all address arithmetic is modulo 2^ADDR_WIDTH.
LEN, 32, word width.
BYTE_SIZE, 8, memory port width.
ICACHE_INDEX_BITS, 4, the icache has 2^ICACHE_INDEX_BITS lines of one word each; tag = addr[ADDR_WIDTH-1:ICACHE_INDEX_BITS+2].

Ports:
clk  in  1  single clock, all logic on posedge.
rst  in  1  synchronous, active-high reset.
inst_fetch_enabled  in  1  fetch request, held until inst_ready.
mem_inst_addr  in  ADDR_WIDTH  fetch address; bits [1:0] ignored (treated as 0).
instruction  out  LEN  fetched word, valid while inst_ready=1, held afterwards.
inst_ready  out  1  one-cycle completion pulse.
mem_vis_enabled  in  1  data request, held until data_ready.
memory_vis_signal  in  2  00 NOP, 01 READ, 10 WRITE, 11 treated as NOP.
mem_vis_size  in  2  00 byte, 01 half, 10/11 word.
mem_sign_ext  in  1  1 = sign-extend byte/half reads, 0 = zero-extend.
mem_data_addr  in  ADDR_WIDTH  data byte address; unaligned addresses allowed.
mem_write_data  in  LEN  store data, low bytes used.
mem_read_data  out  LEN  load result, held until the next load.
data_ready  out  1  one-cycle completion pulse.
icache_flush  in  1  invalidate all icache lines.
mem_data  in  BYTE_SIZE  RAM read byte; returns the byte addressed in the previous cycle.
writen_data  out  BYTE_SIZE  RAM write byte.
mem_vis_addr  out  ADDR_WIDTH  RAM address.
mem_wr  out  1  1 = write this cycle, 0 = read.

Behaviour:
- Reset (sampled at posedge with rst=1):
  - state IDLE; all valid bits 0.
  - Outputs 0: inst_ready, data_ready, mem_wr, mem_vis_addr, writen_data, instruction, mem_read_data.
  - An in-flight access is abandoned; no partial line fill occurs.
- States: IDLE, READ, WRITE, DONE.
- Acceptance happens only in IDLE, at edge E0.
- Arbitration: data request (mem_vis_enabled=1) beats fetch.
- NOP data request: IDLE->DONE; data_ready pulses the next cycle; mem_read_data unchanged.
- Fetch hit (line valid, tag match): IDLE->DONE at E0; instruction = line, inst_ready=1 in the cycle after E0; no RAM activity.
- Fetch miss or data READ of N bytes (N=1/2/4):
  - After edge E_k (k=0..N-1): mem_vis_addr = A+k, mem_wr=0.
  - Byte k is captured at E_{k+1}, little-endian (byte0 -> bits[7:0]).
  - At E_N go to DONE; the ready pulse and result become valid in that cycle.
  - Word fetch/read total: ready in the 5th cycle after the request cycle.
- Miss fill: at E_N write the line (data, tag, valid=1), unless icache_flush=1 at E_N, in which case the line stays invalid.
- Load extension: byte sign/zero-extends bit 7; half extends bit 15; word is unchanged.
- WRITE of N bytes:
  - After E_k: mem_wr=1, mem_vis_addr=A+k, writen_data = byte k of mem_write_data.
  - At E_N: mem_wr=0, DONE, data_ready=1.
- Write-invalidate: at acceptance, clear the valid bit of the icache line holding word (A>>2) and of the line holding word ((A+N-1)>>2), each only if its tag matches.
- DONE always returns to IDLE at the next edge without accepting. The requester therefore has one cycle to drop its request after seeing ready. Minimum request-to-request spacing: hit 2 cycles, word access 6 cycles.
- Idle outputs: mem_wr=0; mem_vis_addr holds its last value.
- icache_flush clears all valid bits at that edge, in any state; it does not disturb an in-progress access.
- Address wrap: A+k wraps modulo 2^ADDR_WIDTH (e.g. 0x1FFFF+1 -> 0x00000).

Test Plan:
1. RAM[0x100..0x103]=13,05,10,00; fetch 0x100 -> addr 0x100..0x103 on successive cycles, inst_ready on cycle 5, instruction=0x00100513; refetch 0x100 -> inst_ready 1 cycle later, mem_vis_addr unchanged.
2. RAM[0x200]=0x80, RAM[0x201]=0xFF; READ byte signext 0x200 -> 0xFFFFFF80; byte zero-ext -> 0x00000080; half signext -> 0xFFFFFF80 with data_ready after 3 cycles.
3. WRITE word 0xDEADBEEF @0x300 -> mem_wr=1 for 4 cycles, writen_data EF,BE,AD,DE at 0x300..0x303; data_ready next cycle.
4. Fetch and data READ asserted together in IDLE -> data served first; fetch accepted only after its DONE+1 cycle; each ready pulses once.
5. Cache 0x100, then WRITE half @0x103 -> line 0x100 invalidated; next fetch 0x100 misses (4 RAM reads) and returns the new bytes.
6. Assert rst during the 3rd byte of a word fetch -> the next cycle shows all outputs 0 and no ready; re-fetch misses; READ word @0x1FFFF reads 0x1FFFF,0x00000,0x00001,0x00002.

Source files
------------

// File: rtl/mem_ctrl_icache.sv
// Memory controller between the CPU IF/MEM stages and a byte-serial RAM port.
// Serves byte/half/word data accesses and word fetches through a direct-mapped icache.
module mem_ctrl_icache #(
  parameter int ADDR_WIDTH        = 17,
  parameter int LEN               = 32,
  parameter int BYTE_SIZE         = 8,
  parameter int ICACHE_INDEX_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_fetch_enabled,
  input  logic [ADDR_WIDTH-1:0] mem_inst_addr,
  output logic [LEN-1:0]        instruction,
  output logic                  inst_ready,
  input  logic                  mem_vis_enabled,
  input  logic [1:0]            memory_vis_signal,
  input  logic [1:0]            mem_vis_size,
  input  logic                  mem_sign_ext,
  input  logic [ADDR_WIDTH-1:0] mem_data_addr,
  input  logic [LEN-1:0]        mem_write_data,
  output logic [LEN-1:0]        mem_read_data,
  output logic                  data_ready,
  input  logic                  icache_flush,
  input  logic [BYTE_SIZE-1:0]  mem_data,
  output logic [BYTE_SIZE-1:0]  writen_data,
  output logic [ADDR_WIDTH-1:0] mem_vis_addr,
  output logic                  mem_wr
);

  localparam int LINES = 1 << ICACHE_INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - ICACHE_INDEX_BITS - 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [ICACHE_INDEX_BITS-1:0] line_index(input logic [ADDR_WIDTH-1:0] a);
    return a[ICACHE_INDEX_BITS+1:2];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_WIDTH-1:0] a);
    return a[ADDR_WIDTH-1:ICACHE_INDEX_BITS+2];
  endfunction

  // Encoded as N-1 so it compares directly against the byte counter.
  function automatic logic [1:0] size_len(input logic [1:0] size);
    logic [1:0] n;
    case (size)
      2'b00:   n = 2'd0;
      2'b01:   n = 2'd1;
      default: n = 2'd3;
    endcase
    return n;
  endfunction

  function automatic logic [BYTE_SIZE-1:0] byte_lane(input logic [LEN-1:0] w, input logic [1:0] k);
    logic [BYTE_SIZE-1:0] b;
    case (k)
      2'd0:    b = w[BYTE_SIZE-1:0];
      2'd1:    b = w[2*BYTE_SIZE-1:BYTE_SIZE];
      2'd2:    b = w[3*BYTE_SIZE-1:2*BYTE_SIZE];
      default: b = w[4*BYTE_SIZE-1:3*BYTE_SIZE];
    endcase
    return b;
  endfunction

  function automatic logic [LEN-1:0] byte_insert(input logic [LEN-1:0] w, input logic [1:0] k,
                                                 input logic [BYTE_SIZE-1:0] b);
    logic [LEN-1:0] r;
    r = w;
    case (k)
      2'd0:    r[BYTE_SIZE-1:0]             = b;
      2'd1:    r[2*BYTE_SIZE-1:BYTE_SIZE]   = b;
      2'd2:    r[3*BYTE_SIZE-1:2*BYTE_SIZE] = b;
      default: r[4*BYTE_SIZE-1:3*BYTE_SIZE] = b;
    endcase
    return r;
  endfunction

  function automatic logic [LEN-1:0] load_extend(input logic [LEN-1:0] raw, input logic [1:0] size,
                                                 input logic sext);
    logic [LEN-1:0] r;
    case (size)
      2'b00:   r = {{(LEN-BYTE_SIZE){sext & raw[BYTE_SIZE-1]}}, raw[BYTE_SIZE-1:0]};
      2'b01:   r = {{(LEN-2*BYTE_SIZE){sext & raw[2*BYTE_SIZE-1]}}, raw[2*BYTE_SIZE-1:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  state_t                 state_r, state_s;
  logic [1:0]             cnt_r, cnt_s;
  logic [1:0]             len_r, len_s;
  logic [ADDR_WIDTH-1:0]  base_addr_r, base_addr_s;
  logic                   is_fetch_r, is_fetch_s;
  logic [1:0]             size_r, size_s;
  logic                   sign_ext_r, sign_ext_s;
  logic [LEN-1:0]         wdata_r, wdata_s;
  logic [LEN-1:0]         buf_r, buf_s;
  logic [ADDR_WIDTH-1:0]  vis_addr_r, vis_addr_s;
  logic                   mem_wr_r, mem_wr_s;
  logic [BYTE_SIZE-1:0]   writen_data_r, writen_data_s;
  logic [LEN-1:0]         instruction_r, instruction_s;
  logic [LEN-1:0]         read_data_r, read_data_s;
  logic                   inst_ready_r, inst_ready_s;
  logic                   data_ready_r, data_ready_s;

  logic [LINES-1:0]       valid_r, valid_s;
  logic [TAG_W-1:0]       tag_r  [LINES];
  logic [LEN-1:0]         data_r [LINES];

  logic                   fill_en_s;
  logic [LEN-1:0]         word_s;

  logic [ADDR_WIDTH-1:0]        fetch_base_s;
  logic [ICACHE_INDEX_BITS-1:0] fetch_idx_s;
  logic                         fetch_hit_s;
  logic [1:0]                   acc_len_s;
  logic [ADDR_WIDTH-1:0]        last_addr_s;
  logic [ICACHE_INDEX_BITS-1:0] first_idx_s, last_idx_s;
  logic                         first_match_s, last_match_s;

  assign fetch_base_s  = mem_inst_addr & ~{{(ADDR_WIDTH-2){1'b0}}, 2'b11};
  assign fetch_idx_s   = line_index(fetch_base_s);
  assign fetch_hit_s   = valid_r[fetch_idx_s] && (tag_r[fetch_idx_s] == tag_of(fetch_base_s));
  assign acc_len_s     = size_len(mem_vis_size);
  assign last_addr_s   = mem_data_addr + {{(ADDR_WIDTH-2){1'b0}}, acc_len_s};
  assign first_idx_s   = line_index(mem_data_addr);
  assign last_idx_s    = line_index(last_addr_s);
  assign first_match_s = (tag_r[first_idx_s] == tag_of(mem_data_addr));
  assign last_match_s  = (tag_r[last_idx_s] == tag_of(last_addr_s));

  assign instruction   = instruction_r;
  assign inst_ready    = inst_ready_r;
  assign mem_read_data = read_data_r;
  assign data_ready    = data_ready_r;
  assign writen_data   = writen_data_r;
  assign mem_vis_addr  = vis_addr_r;
  assign mem_wr        = mem_wr_r;

  // Next-state, next-output and icache valid-bit logic.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    len_s         = len_r;
    base_addr_s   = base_addr_r;
    is_fetch_s    = is_fetch_r;
    size_s        = size_r;
    sign_ext_s    = sign_ext_r;
    wdata_s       = wdata_r;
    buf_s         = buf_r;
    vis_addr_s    = vis_addr_r;
    mem_wr_s      = 1'b0;
    writen_data_s = writen_data_r;
    instruction_s = instruction_r;
    read_data_s   = read_data_r;
    inst_ready_s  = 1'b0;
    data_ready_s  = 1'b0;
    valid_s       = valid_r;
    fill_en_s     = 1'b0;
    word_s        = buf_r;
    case (state_r)
      IDLE: begin
        if (mem_vis_enabled) begin
          base_addr_s = mem_data_addr;
          cnt_s       = 2'd0;
          len_s       = acc_len_s;
          is_fetch_s  = 1'b0;
          size_s      = mem_vis_size;
          sign_ext_s  = mem_sign_ext;
          case (memory_vis_signal)
            2'b01: begin
              state_s    = READ;
              vis_addr_s = mem_data_addr;
              buf_s      = '0;
            end
            2'b10: begin
              state_s       = WRITE;
              vis_addr_s    = mem_data_addr;
              mem_wr_s      = 1'b1;
              wdata_s       = mem_write_data;
              writen_data_s = byte_lane(mem_write_data, 2'd0);
              // Keep fetched code coherent with stores that touch a cached word.
              if (first_match_s) begin
                valid_s[first_idx_s] = 1'b0;
              end else begin
                valid_s[first_idx_s] = valid_r[first_idx_s];
              end
              if (last_match_s) begin
                valid_s[last_idx_s] = 1'b0;
              end else begin
                valid_s[last_idx_s] = valid_s[last_idx_s];
              end
            end
            default: begin
              state_s      = DONE;
              data_ready_s = 1'b1;
            end
          endcase
        end else if (inst_fetch_enabled) begin
          if (fetch_hit_s) begin
            state_s       = DONE;
            instruction_s = data_r[fetch_idx_s];
            inst_ready_s  = 1'b1;
          end else begin
            state_s     = READ;
            base_addr_s = fetch_base_s;
            vis_addr_s  = fetch_base_s;
            cnt_s       = 2'd0;
            len_s       = 2'd3;
            is_fetch_s  = 1'b1;
            size_s      = 2'b10;
            sign_ext_s  = 1'b0;
            buf_s       = '0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        word_s = byte_insert(buf_r, cnt_r, mem_data);
        buf_s  = word_s;
        if (cnt_r == len_r) begin
          state_s = DONE;
          if (is_fetch_r) begin
            instruction_s = word_s;
            inst_ready_s  = 1'b1;
            fill_en_s     = 1'b1;
            valid_s[line_index(base_addr_r)] = 1'b1;
          end else begin
            read_data_s  = load_extend(word_s, size_r, sign_ext_r);
            data_ready_s = 1'b1;
          end
        end else begin
          cnt_s      = cnt_r + 2'd1;
          vis_addr_s = base_addr_r + {{(ADDR_WIDTH-2){1'b0}}, cnt_s};
        end
      end
      WRITE: begin
        if (cnt_r == len_r) begin
          state_s      = DONE;
          data_ready_s = 1'b1;
        end else begin
          cnt_s         = cnt_r + 2'd1;
          vis_addr_s    = base_addr_r + {{(ADDR_WIDTH-2){1'b0}}, cnt_s};
          mem_wr_s      = 1'b1;
          writen_data_s = byte_lane(wdata_r, cnt_s);
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control and output registers; flush overrides any same-edge fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      cnt_r         <= 2'd0;
      len_r         <= 2'd0;
      base_addr_r   <= '0;
      is_fetch_r    <= 1'b0;
      size_r        <= 2'b00;
      sign_ext_r    <= 1'b0;
      wdata_r       <= '0;
      buf_r         <= '0;
      vis_addr_r    <= '0;
      mem_wr_r      <= 1'b0;
      writen_data_r <= '0;
      instruction_r <= '0;
      read_data_r   <= '0;
      inst_ready_r  <= 1'b0;
      data_ready_r  <= 1'b0;
      valid_r       <= '0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      len_r         <= len_s;
      base_addr_r   <= base_addr_s;
      is_fetch_r    <= is_fetch_s;
      size_r        <= size_s;
      sign_ext_r    <= sign_ext_s;
      wdata_r       <= wdata_s;
      buf_r         <= buf_s;
      vis_addr_r    <= vis_addr_s;
      mem_wr_r      <= mem_wr_s;
      writen_data_r <= writen_data_s;
      instruction_r <= instruction_s;
      read_data_r   <= read_data_s;
      inst_ready_r  <= inst_ready_s;
      data_ready_r  <= data_ready_s;
      valid_r       <= icache_flush ? {LINES{1'b0}} : valid_s;
    end
  end

  // Icache tag/data storage; contents are meaningless while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (fill_en_s && !rst) begin
      tag_r[line_index(base_addr_r)]  <= tag_of(base_addr_r);
      data_r[line_index(base_addr_r)] <= word_s;
    end
  end

endmodule
